// File: rtl/sico_count_checker.sv
// Consuming end of a free-running counter stream: locks onto the first sample, checks +1 steps,
// keeps sample/error statistics and serves them over a four-phase req/ack readout port.
module sico_count_checker #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned ERRW   = 16,
   parameter int unsigned RESYNC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] val_i,
   input  logic             val_valid_i,
   input  logic             clr_i,
   input  logic             rd_req_i,
   input  logic [1:0]       rd_sel_i,
   output logic             rd_ack_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             locked_o,
   output logic             err_o
);

   typedef enum logic {StUnlocked, StLocked} chk_state_e;
   typedef enum logic {StIdle, StAck} rd_state_e;

   chk_state_e       chk_state_q, chk_state_d;
   rd_state_e        rd_state_q, rd_state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
   logic             ferr_q, ferr_d;
   logic [WIDTH-1:0] ferr_rcv_q, ferr_rcv_d;
   logic [WIDTH-1:0] ferr_exp_q, ferr_exp_d;
   logic             err_q, err_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] sel_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_state_q <= StUnlocked;
         rd_state_q  <= StIdle;
         exp_q       <= '0;
         cnt_q       <= '0;
         err_cnt_q   <= '0;
         ferr_q      <= 1'b0;
         ferr_rcv_q  <= '0;
         ferr_exp_q  <= '0;
         err_q       <= 1'b0;
         ack_q       <= 1'b0;
         data_q      <= '0;
      end else begin
         chk_state_q <= chk_state_d;
         rd_state_q  <= rd_state_d;
         exp_q       <= exp_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         ferr_q      <= ferr_d;
         ferr_rcv_q  <= ferr_rcv_d;
         ferr_exp_q  <= ferr_exp_d;
         err_q       <= err_d;
         ack_q       <= ack_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      chk_state_d = chk_state_q;
      exp_d       = exp_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      ferr_d      = ferr_q;
      ferr_rcv_d  = ferr_rcv_q;
      ferr_exp_d  = ferr_exp_q;
      if (val_valid_i) begin
         cnt_d = cnt_q + WIDTH'(1);
         if (chk_state_q == StUnlocked) begin
            exp_d       = val_i + WIDTH'(1);
            chk_state_d = StLocked;
         end else if (val_i == exp_q) begin
            exp_d = exp_q + WIDTH'(1);
         end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRW'(1);
            if (!ferr_q) begin
               ferr_d     = 1'b1;
               ferr_rcv_d = val_i;
               ferr_exp_d = exp_q;
            end
            exp_d = (RESYNC != 0) ? val_i + WIDTH'(1) : exp_q + WIDTH'(1);
         end
      end
      // Clear wins for statistics only; lock/expected tracking above is kept.
      if (clr_i) begin
         cnt_d      = '0;
         err_cnt_d  = '0;
         ferr_d     = 1'b0;
         ferr_rcv_d = '0;
         ferr_exp_d = '0;
      end
      err_d = (err_cnt_d != '0);
   end

   always_comb begin
      case (rd_sel_i)
         2'd0:    sel_data = cnt_q;
         2'd1:    sel_data = WIDTH'(err_cnt_q);
         2'd2:    sel_data = ferr_q ? ferr_rcv_q : '0;
         default: sel_data = ferr_q ? ferr_exp_q : '0;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      ack_d      = ack_q;
      data_d     = data_q;
      case (rd_state_q)
         StIdle: begin
            if (rd_req_i) begin
               data_d     = sel_data;
               ack_d      = 1'b1;
               rd_state_d = StAck;
            end
         end
         default: begin
            if (!rd_req_i) begin
               ack_d      = 1'b0;
               rd_state_d = StIdle;
            end
         end
      endcase
   end

   assign rd_ack_o  = ack_q;
   assign rd_data_o = data_q;
   assign locked_o  = (chk_state_q == StLocked);
   assign err_o     = err_q;

endmodule
